flux_burst_scheduler: RTL and testbench
=======================================

// Module: flux_burst_scheduler
// PURPOSE
//  Sequential round-robin scheduler for multi-flux (tagged) HEVC parallel actors. Replaces the
//  per-cycle fixed-priority flux pick with a fair round-robin pick locked for a burst of BURST_LEN
//  tokens (e.g. 8 samples per 8-tap filter pass). It drives the actor's per-flux read strobes, its
//  write strobe and its tag. The actor datapath only transforms dout into din.
// PARAMETERS
//  FLUX       2   number of interleaved data fluxes (>=2)
//  BURST_LEN  8   tokens transferred per grant before re-arbitration (>=1)
//  STALL_MAX  16  consecutive stalled cycles before a lock is released (used only with FLUX_STALL_RELEASE_EN)
//  TAG_WIDTH  $clog2(FLUX)  derived localparam, not overridable
// PORTS
//  clk         in   1            single clock, rising edge
//  rst_n       in   1            asynchronous active-low reset
//  in_empty    in   FLUX         empty flags of the input FIFOs, one per flux
//  out_full    in   FLUX         full flags of the output FIFOs, one per flux
//  abort       in   1            synchronous flush: drop the current lock
//  rd          out  FLUX         one-hot read strobe to the input FIFOs (all 0 when no transfer)
//  wr          out  1            write strobe to the output FIFO
//  tag         out  TAG_WIDTH+1  {invalid, flux index}; MSB=1 means no grant (codebase convention)
//  burst_last  out  1            the current transfer is the final token of the burst
// BEHAVIOUR
//  - eligible[i] = !in_empty[i] & !out_full[i]. fire = (state==LOCK) & eligible[tag_q]. Combinational.
//  - rd[tag_q] = fire, other rd bits = 0. wr = fire. burst_last = fire & (cnt==BURST_LEN-1).
//  - tag = {state!=LOCK, tag_q}. The tag is valid for the whole lock, including stalled cycles.
//  - FSM states IDLE and LOCK. Registers: state, tag_q, last_q, cnt (width $clog2(BURST_LEN+1)).
//  - IDLE: if any eligible bit is set, select the first eligible index scanning last_q+1 .. last_q+FLUX
//    modulo FLUX. Load tag_q with that index, load last_q with the same index, clear cnt, go to LOCK.
//    If no bit is eligible, stay in IDLE. No transfer happens in IDLE (1-cycle arbitration latency).
//  - LOCK: a fire increments cnt. A fire with cnt==BURST_LEN-1 returns to IDLE (1 bubble cycle
//    between bursts). A non-fire cycle holds everything; the lock stays and cnt is kept.
//  - abort has priority over everything: next state IDLE, cnt cleared, last_q kept. A fire in the same
//    cycle still completes, because rd/wr are combinational this cycle.
//  - Wrap: the round-robin scan wraps FLUX-1 -> 0. cnt never exceeds BURST_LEN-1.
//  - Reset, async at any point including mid-burst: state=IDLE, tag_q=0, last_q=FLUX-1 (flux 0 wins
//    first), cnt=0. Outputs during reset: rd=0, wr=0, burst_last=0, tag MSB=1.
//  - Simultaneous events: in_empty and out_full are sampled each cycle with no registering.
//    A flag that drops in the same cycle blocks that cycle's fire.
// CONFIGURATION
//  - FLUX_STALL_RELEASE_EN defined: adds a stall counter (width $clog2(STALL_MAX+1)). It increments
//    in each LOCK cycle without a fire and clears on a fire or when entering LOCK. When it reaches
//    STALL_MAX-1 in a non-fire cycle, next state is IDLE and cnt is cleared. The partial burst is
//    abandoned and last_q keeps the stalled flux, so the stalled flux is scanned last.
//  - FLUX_STALL_RELEASE_EN undefined: no stall counter. The lock holds until the burst completes,
//    abort is asserted or reset occurs. STALL_MAX is ignored.
// STRUCTURE
//  - Package flux_sched_pkg: the typedef enum logic {IDLE, LOCK} sched_state_t, and the
//    function rr_next(eligible, last) shared with other multi-flux actors.
//  - One sub-module, rr_pick: a combinational rotate-priority encoder. Inputs eligible[FLUX],
//    last[TAG_WIDTH-1:0]; outputs idx and any.
//  - Top level: FSM, counters and output decode only. It has no data path.
// TESTING
//  T1 FLUX=2, BURST_LEN=8, both fluxes always eligible -> grants alternate 0,1,0,1. Each burst is
//     8 consecutive wr pulses then 1 idle cycle. burst_last is high on the 8th pulse.
//  T2 out_full[0] raised for 5 cycles after the 3rd fire of a flux-0 burst -> no rd/wr during those
//     5 cycles, tag stays 0 with MSB=0, then 5 more fires, then flux 1 is granted.
//  T3 FLUX=4, only fluxes 1 and 3 non-empty, last_q=3 -> grant order 1,3,1,3. Fluxes 0 and 2 are never
//     strobed. Also check the wrap 3->1.
//  T4 abort pulsed after the 4th fire of a flux-1 burst -> that cycle's fire completes, IDLE next
//     cycle, next grant goes to the next eligible flux after 1.
//  T5 rst_n asserted mid-burst (cnt=5) -> rd=0, wr=0 and tag=3'b1xx immediately without waiting for a
//     clock. After release, the first grant is flux 0 and cnt restarts at 0.
//  T6 With FLUX_STALL_RELEASE_EN and STALL_MAX=16, flux 0 is locked and empty for 16 cycles -> lock
//     released, flux 1 granted 1 cycle later. Without the macro, the lock is held indefinitely.

Source files
------------

// File: rtl/flux_burst_scheduler_pkg.sv
// Shared types and the round-robin scan used by the multi-flux actors.
// Grant selection is a rotating-priority scan that starts just after the last granted flux.
package flux_sched_pkg;

   typedef enum logic {IDLE, LOCK} sched_state_t;

   localparam int MAX_FLUX = 64;
   localparam int IDXW     = $clog2(MAX_FLUX);

   // Scans last+1 .. last+nflux modulo nflux; returns last when nothing is eligible.
   function automatic logic [31:0] rr_next(input logic [MAX_FLUX-1:0] eligible,
                                           input logic [31:0]         last,
                                           input logic [31:0]         nflux);
      logic [31:0] pick;
      logic [31:0] cand;
      logic        found;
      pick  = last;
      found = 1'b0;
      for (int off = 1; off <= MAX_FLUX; off++) begin
         cand = (last + 32'(off)) % nflux;
         if (!found && (32'(off) <= nflux) && eligible[cand[IDXW-1:0]]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/flux_burst_scheduler_if.sv
// Handshake bundle between the scheduler and the actor's input/output FIFOs.
// The slave side is the scheduler; the master side owns the FIFO flags and abort.
interface flux_burst_scheduler_if #(
   parameter int FLUX = 2
);
   localparam int TAG_WIDTH = $clog2(FLUX);

   logic [FLUX-1:0]    in_empty;
   logic [FLUX-1:0]    out_full;
   logic               abort;
   logic [FLUX-1:0]    rd;
   logic               wr;
   logic [TAG_WIDTH:0] tag;
   logic               burst_last;

   modport master (
      output in_empty, out_full, abort,
      input  rd, wr, tag, burst_last
   );

   modport slave (
      input  in_empty, out_full, abort,
      output rd, wr, tag, burst_last
   );
endinterface

// File: rtl/flux_burst_scheduler_rr_pick.sv
// Combinational rotate-priority encoder: first eligible flux after 'last', wrapping FLUX-1 -> 0.
// Zero latency; 'any' low means no flux can be granted this cycle.
module rr_pick
   import flux_sched_pkg::*;
#(
   parameter int FLUX = 2
) (
   input  logic [FLUX-1:0]          eligible,
   input  logic [$clog2(FLUX)-1:0]  last,
   output logic [$clog2(FLUX)-1:0]  idx,
   output logic                     any
);
   localparam int TAG_WIDTH = $clog2(FLUX);

   assign idx = TAG_WIDTH'(rr_next(MAX_FLUX'(eligible), 32'(last), 32'(FLUX)));
   assign any = |eligible;

endmodule

// File: rtl/flux_burst_scheduler.sv
// Round-robin burst scheduler: locks one flux for BURST_LEN tokens, 1-cycle arbitration bubble.
// Stalls on empty/full hold the lock; FLUX_STALL_RELEASE_EN adds a stall timeout that drops it.
module flux_burst_scheduler
   import flux_sched_pkg::*;
#(
   parameter int FLUX      = 2,
   parameter int BURST_LEN = 8,
   parameter int STALL_MAX = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   flux_burst_scheduler_if.slave bus
);
   localparam int TAG_WIDTH = $clog2(FLUX);
   localparam int CNT_W     = $clog2(BURST_LEN + 1);

   sched_state_t         state_q, state_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic [TAG_WIDTH-1:0] last_q, last_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [TAG_WIDTH-1:0] pick_idx;
   logic [FLUX-1:0]      eligible;
   logic                 pick_any;
   logic                 fire;
   logic                 cnt_end;

`ifdef FLUX_STALL_RELEASE_EN
   localparam int STALL_W = $clog2(STALL_MAX + 1);
   logic [STALL_W-1:0] stall_q, stall_d;
`endif

   rr_pick #(.FLUX(FLUX)) u_rr_pick (
      .eligible (eligible),
      .last     (last_q),
      .idx      (pick_idx),
      .any      (pick_any)
   );

   always_comb begin
      eligible = ~bus.in_empty & ~bus.out_full;
      fire     = (state_q == LOCK) && eligible[tag_q];
      cnt_end  = (cnt_q == CNT_W'(BURST_LEN - 1));
   end

   // Strobes are combinational so a flag change blocks the transfer in the same cycle.
   assign bus.rd         = fire ? (FLUX'(1) << tag_q) : '0;
   assign bus.wr         = fire;
   assign bus.burst_last = fire & cnt_end;
   assign bus.tag        = {state_q != LOCK, tag_q};

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
`ifdef FLUX_STALL_RELEASE_EN
      stall_d = stall_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = LOCK;
               tag_d   = pick_idx;
               last_d  = pick_idx;
               cnt_d   = '0;
            end
`ifdef FLUX_STALL_RELEASE_EN
            stall_d = '0;
`endif
         end
         LOCK: begin
            if (fire) begin
               if (cnt_end) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
`ifdef FLUX_STALL_RELEASE_EN
               stall_d = '0;
            end else if (stall_q == STALL_W'(STALL_MAX - 1)) begin
               // Abandon the partial burst; last_q still names the stalled flux so it is scanned last.
               state_d = IDLE;
               cnt_d   = '0;
               stall_d = '0;
            end else begin
               stall_d = stall_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.abort) begin
         state_d = IDLE;
         tag_d   = tag_q;
         last_d  = last_q;
         cnt_d   = '0;
`ifdef FLUX_STALL_RELEASE_EN
         stall_d = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tag_q   <= '0;
         last_q  <= TAG_WIDTH'(FLUX - 1);
         cnt_q   <= '0;
`ifdef FLUX_STALL_RELEASE_EN
         stall_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
`ifdef FLUX_STALL_RELEASE_EN
         stall_q <= stall_d;
`endif
      end
   end

endmodule

// File: tb/tb_flux_burst_scheduler.sv
// Scoreboard bench: two schedulers (FLUX=2 and FLUX=4), expected transfers queued per instance.
module tb_flux_burst_scheduler;
   import flux_sched_pkg::*;

   localparam int BURST_LEN = 8;
   localparam int STALL_MAX = 16;

   logic clk;
   logic rst_a_n;
   logic rst_b_n;

   flux_burst_scheduler_if #(.FLUX(2)) a_if ();
   flux_burst_scheduler_if #(.FLUX(4)) b_if ();

   flux_burst_scheduler #(.FLUX(2), .BURST_LEN(BURST_LEN), .STALL_MAX(STALL_MAX)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_a_n),
      .bus   (a_if)
   );

   flux_burst_scheduler #(.FLUX(4), .BURST_LEN(BURST_LEN), .STALL_MAX(STALL_MAX)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_b_n),
      .bus   (b_if)
   );

   typedef struct {
      logic [3:0] rd;
      logic [2:0] tag;
      logic       last;
   } exp_t;

   exp_t exp_a[$];
   exp_t exp_b[$];
   exp_t ea;
   exp_t eb;

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_burst(input bit to_b, input int flux, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.rd   = 4'(1) << flux;
         e.tag  = 3'(flux);
         e.last = (k == BURST_LEN - 1);
         if (to_b) exp_b.push_back(e);
         else      exp_a.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitors: every write strobe must match the next queued transfer.
   always @(negedge clk) begin
      if (a_if.wr) begin
         if (exp_a.size() == 0) begin
            check("a_unexpected_wr", 32'(a_if.rd), 32'(0));
         end else begin
            ea = exp_a.pop_front();
            check("a_rd",   32'({2'b00, a_if.rd}), 32'(ea.rd));
            check("a_tag",  32'({1'b0, a_if.tag}), 32'(ea.tag));
            check("a_last", 32'(a_if.burst_last), 32'(ea.last));
         end
      end
   end

   always @(negedge clk) begin
      if (b_if.wr) begin
         if (exp_b.size() == 0) begin
            check("b_unexpected_wr", 32'(b_if.rd), 32'(0));
         end else begin
            eb = exp_b.pop_front();
            check("b_rd",   32'(b_if.rd), 32'(eb.rd));
            check("b_tag",  32'(b_if.tag), 32'(eb.tag));
            check("b_last", 32'(b_if.burst_last), 32'(eb.last));
         end
      end
   end

   initial begin
      rst_a_n         = 1'b0;
      rst_b_n         = 1'b0;
      a_if.in_empty   = '1;
      a_if.out_full   = '0;
      a_if.abort      = 1'b0;
      b_if.in_empty   = '1;
      b_if.out_full   = '0;
      b_if.abort      = 1'b0;

      #3;
      check("rst_a_tag_msb", 32'(a_if.tag[1]), 32'(1));
      check("rst_a_rd",      32'(a_if.rd), 32'(0));
      check("rst_a_wr",      32'(a_if.wr), 32'(0));
      check("rst_a_last",    32'(a_if.burst_last), 32'(0));
      check("rst_b_tag_msb", 32'(b_if.tag[2]), 32'(1));
      check("rst_b_wr",      32'(b_if.wr), 32'(0));

      repeat (2) @(posedge clk);
      #1;
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;
      tick();

      // T1: both fluxes eligible -> 0,1,0,1, each 8 writes plus one bubble
      a_if.in_empty = 2'b00;
      push_burst(0, 0, 8);
      push_burst(0, 1, 8);
      push_burst(0, 0, 8);
      push_burst(0, 1, 8);
      for (int c = 0; c < 36; c++) begin
         @(negedge clk);
         check("t1_wr", 32'(a_if.wr), 32'((c % 9) != 0));
      end
      tick();
      a_if.in_empty = 2'b11;
      tick();

      // T2: out_full[0] for 5 cycles after the 3rd fire of a flux-0 burst
      a_if.in_empty = 2'b00;
      push_burst(0, 0, 8);
      push_burst(0, 1, 8);
      for (int c = 0; c < 23; c++) begin
         @(negedge clk);
         check("t2_wr", 32'(a_if.wr),
               32'(((c >= 1) && (c <= 3)) || ((c >= 9) && (c <= 13)) || (c >= 15)));
         if ((c >= 4) && (c <= 8)) check("t2_stall_tag", 32'(a_if.tag), 32'(0));
         tick();
         a_if.out_full = {1'b0, ((c + 1) >= 4) && ((c + 1) <= 8)};
      end
      a_if.in_empty = 2'b11;
      a_if.out_full = 2'b00;
      tick();

      // T4: abort during the 4th fire of a flux-1 burst
      a_if.in_empty = 2'b01;
      push_burst(0, 1, 4);
      push_burst(0, 0, 8);
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         check("t4_wr", 32'(a_if.wr), 32'(((c >= 1) && (c <= 4)) || (c >= 6)));
         if (c == 5) check("t4_idle_tag_msb", 32'(a_if.tag[1]), 32'(1));
         tick();
         a_if.abort    = ((c + 1) == 4);
         a_if.in_empty = ((c + 1) >= 5) ? 2'b00 : 2'b01;
      end
      a_if.in_empty = 2'b11;
      a_if.abort    = 1'b0;
      tick();

      // T6: flux 0 locked then starved
      a_if.in_empty = 2'b10;
`ifdef FLUX_STALL_RELEASE_EN
      push_burst(0, 1, 8);
`endif
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
`ifdef FLUX_STALL_RELEASE_EN
         check("t6_wr", 32'(a_if.wr), 32'(c >= 18));
         if ((c >= 1) && (c <= 16)) check("t6_lock_tag", 32'(a_if.tag), 32'(0));
         if (c == 17) check("t6_release_tag_msb", 32'(a_if.tag[1]), 32'(1));
`else
         check("t6_wr", 32'(a_if.wr), 32'(0));
         if (c >= 1) check("t6_hold_tag", 32'(a_if.tag), 32'(0));
`endif
         tick();
         a_if.in_empty = 2'b01;
      end
      a_if.in_empty = 2'b11;

      // T3: FLUX=4, only fluxes 1 and 3 present -> 1,3,1,3
      b_if.in_empty = 4'b0101;
      push_burst(1, 1, 8);
      push_burst(1, 3, 8);
      push_burst(1, 1, 8);
      push_burst(1, 3, 8);
      for (int c = 0; c < 36; c++) begin
         @(negedge clk);
         check("t3_wr", 32'(b_if.wr), 32'((c % 9) != 0));
      end
      tick();
      b_if.in_empty = 4'b1111;
      tick();

      // T5: async reset while cnt=5
      b_if.in_empty = 4'b0000;
      push_burst(1, 0, 5);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("t5_wr", 32'(b_if.wr), 32'(c != 0));
         tick();
      end
      check("t5_pre_rst_wr", 32'(b_if.wr), 32'(1));
      #1;
      rst_b_n = 1'b0;
      #1;
      check("t5_rst_rd",      32'(b_if.rd), 32'(0));
      check("t5_rst_wr",      32'(b_if.wr), 32'(0));
      check("t5_rst_tag_msb", 32'(b_if.tag[2]), 32'(1));
      check("t5_rst_last",    32'(b_if.burst_last), 32'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_b_n = 1'b1;
      push_burst(1, 0, 8);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         check("t5_post_wr", 32'(b_if.wr), 32'(c != 0));
         tick();
      end
      b_if.in_empty = 4'b1111;

      repeat (3) tick();
      check("a_queue_empty", 32'(exp_a.size()), 32'(0));
      check("b_queue_empty", 32'(exp_b.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
